// File: rtl/arith_pkg.sv
// Shared op codes, FSM states and default widths for the arithmetic execution unit.
package arith_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] SAT_POS_DEF = 16'h7FFF;
    localparam logic [DATA_W_DEF-1:0] SAT_NEG_DEF = 16'h8000;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/arith_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, Q_W cycles after start.
module arith_divider
    import arith_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int Q_W    = DATA_W_DEF + FRAC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [Q_W-1:0]    dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output logic [Q_W-1:0]    quotient_o
);

    localparam int CNT_W = $clog2(Q_W);

    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]    quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   trial, diff;
    logic              fits;

    // A zero divisor always "fits", giving an all-ones quotient that the top saturates.
    always_comb begin
        trial = {rem_q, quo_q[Q_W-1]};
        diff  = trial - {1'b0, dvs_q};
        fits  = (trial >= {1'b0, dvs_q});
        rem_d = fits ? DATA_W'(diff) : DATA_W'(trial);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CNT_W'(Q_W - 1);
        end else if (run_q) begin
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (run_q) begin
            quo_q <= {quo_q[Q_W-2:0], fits};
            rem_q <= rem_d;
        end
    end

    assign done_o     = run_q && (cnt_q == '0);
    assign quotient_o = quo_q;

endmodule

// File: rtl/arith_exec_unit.sv
// Data bank plus single-cycle ADD/SUB/MUL and iterative DIV with a continue handshake.
// Define ARITH_SAT_EN to saturate ADD/SUB/MUL on overflow instead of wrapping.
module arith_exec_unit
    import arith_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ctl_a,
    input  logic [ADDR_W-1:0] ctl_b,
    input  logic [1:0]        ctl_d,
    input  logic              ctl_e,
    input  logic              ctl_f,
    output logic              continue_o,
    output logic              busy,
    output logic              div_zero,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int Q_W   = DATA_W + FRAC_W;
    localparam int PW    = 2 * DATA_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [Q_W-1:0] MAG_POS = Q_W'((1 << (DATA_W - 1)) - 1);
    localparam logic [Q_W-1:0] MAG_NEG = Q_W'(1 << (DATA_W - 1));

`ifdef ARITH_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] fit_alu(input logic signed [PW-1:0] v);
        if (v > PW'(SAT_POS)) return SAT_POS;
        if (v < PW'(SAT_NEG)) return SAT_NEG;
        return DATA_W'(v);
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] fit_alu(input logic signed [PW-1:0] v);
        return DATA_W'(v);
    endfunction
`endif

    // Magnitude is clamped first, then the sign is applied.
    function automatic logic signed [DATA_W-1:0] div_sat(input logic [Q_W-1:0] mag,
                                                         input logic           neg);
        logic [Q_W-1:0]    lim;
        logic [DATA_W-1:0] m;
        lim = neg ? MAG_NEG : MAG_POS;
        m   = (mag > lim) ? DATA_W'(lim) : DATA_W'(mag);
        return neg ? -m : m;
    endfunction

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  bank_q [DEPTH];
    logic signed [DATA_W-1:0]  op_a, op_b, alu_res, wr_data;
    logic [DATA_W-1:0]         abs_a, abs_b;
    logic                      div_neg_q, div_zero_q;
    logic                      div_start, div_done, int_we;
    logic [Q_W-1:0]            div_quo;

    assign op_a      = bank_q[ctl_a];
    assign op_b      = bank_q[ctl_b];
    assign abs_a     = op_a[DATA_W-1] ? DATA_W'(-op_a) : op_a;
    assign abs_b     = op_b[DATA_W-1] ? DATA_W'(-op_b) : op_b;
    assign div_start = (state_q == IDLE) && ctl_e && (ctl_d == OP_DIV);

    always_comb begin
        alu_res = fit_alu(PW'(op_a) + PW'(op_b));
        case (ctl_d)
            OP_SUB:  alu_res = fit_alu(PW'(op_a) - PW'(op_b));
            OP_MUL:  alu_res = fit_alu((PW'(op_a) * PW'(op_b)) >>> FRAC_W);
            default: alu_res = fit_alu(PW'(op_a) + PW'(op_b));
        endcase
    end

    arith_divider #(
        .DATA_W (DATA_W),
        .Q_W    (Q_W)
    ) u_div (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (div_start),
        .dividend_i ({abs_a, {FRAC_W{1'b0}}}),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_comb begin
        state_d = state_q;
        int_we  = 1'b0;
        wr_data = alu_res;
        case (state_q)
            IDLE: begin
                int_we = ctl_f && (ctl_d != OP_DIV);
                if (div_start) state_d = DIV_RUN;
            end
            DIV_RUN: begin
                if (div_done) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                int_we  = ctl_f;
                wr_data = div_sat(div_quo, div_neg_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (div_start) begin
            div_neg_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            div_zero_q <= (op_b == '0);
        end
    end

    // Bench load wins over an internal write to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            if (int_we && !(ld_we && (ld_addr == ctl_a))) bank_q[ctl_a] <= wr_data;
            if (ld_we) bank_q[ld_addr] <= ld_data;
        end
    end

    assign continue_o = (state_q == DIV_DONE);
    assign busy       = (state_q != IDLE);
    assign div_zero   = div_zero_q;
    assign rd_data    = bank_q[rd_addr];

endmodule

// File: tb/tb_arith_exec_unit.sv
// Directed scoreboard bench for arith_exec_unit; expectations come from a bench-side bank mirror.
module tb_arith_exec_unit;
    import arith_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int QW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ctl_a, ctl_b, ld_addr, rd_addr;
    logic [1:0]    ctl_d;
    logic          ctl_e, ctl_f, ld_we;
    logic [DW-1:0] ld_data, rd_data;
    logic          continue_o, busy, div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mdl [32];
    logic [AW-1:0] sb_addr [$];
    logic [DW-1:0] sb_val  [$];
    string         sb_tag  [$];

    always #5 clk = ~clk;

    arith_exec_unit #(.DATA_W(DW), .FRAC_W(8), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl_a      (ctl_a),
        .ctl_b      (ctl_b),
        .ctl_d      (ctl_d),
        .ctl_e      (ctl_e),
        .ctl_f      (ctl_f),
        .continue_o (continue_o),
        .busy       (busy),
        .div_zero   (div_zero),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] m_fit(input longint v);
`ifdef ARITH_SAT_EN
        if (v > 32767)  return SAT_POS_DEF;
        if (v < -32768) return SAT_NEG_DEF;
`endif
        return v[15:0];
    endfunction

    function automatic logic [DW-1:0] m_alu(input logic [1:0] d, input logic [DW-1:0] a, b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (d)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            default: r = (sa * sb) >>> 8;
        endcase
        return m_fit(r);
    endfunction

    function automatic logic [DW-1:0] m_div(input logic [DW-1:0] a, b);
        longint sa, sb, q, r;
        bit     neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return (sa >= 0) ? SAT_POS_DEF : SAT_NEG_DEF;
        neg = (sa < 0) != (sb < 0);
        q = ((sa < 0 ? -sa : sa) * 256) / (sb < 0 ? -sb : sb);
        if (!neg) begin
            if (q > 32767) return SAT_POS_DEF;
            return q[15:0];
        end
        if (q > 32768) return SAT_NEG_DEF;
        r = -q;
        return r[15:0];
    endfunction

    task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ld_we   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        mdl[addr] = data;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic push(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] val);
        sb_tag.push_back(tag);
        sb_addr.push_back(addr);
        sb_val.push_back(val);
        mdl[addr] = val;
    endtask

    task automatic pop_check();
        string         tag;
        logic [DW-1:0] val;
        if (sb_val.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        tag     = sb_tag.pop_front();
        rd_addr = sb_addr.pop_front();
        val     = sb_val.pop_front();
        #1;
        check(tag, rd_data, val);
    endtask

    task automatic op_single(input logic [AW-1:0] a, b, input logic [1:0] d, input string tag);
        logic [DW-1:0] e;
        e = m_alu(d, mdl[a], mdl[b]);
        ctl_a = a; ctl_b = b; ctl_d = d; ctl_e = 1'b1; ctl_f = 1'b1;
        push(tag, a, e);
        #1;
        check({tag, "_cont"}, continue_o, 1'b0);
        tick();
        ctl_e = 1'b0; ctl_f = 1'b0;
        pop_check();
    endtask

    task automatic run_div(input logic [AW-1:0] a, b, input bit clobber, input string tag);
        logic [DW-1:0] old_v, exp_v;
        bit            zero;
        int            lat;
        old_v = mdl[a];
        exp_v = m_div(mdl[a], mdl[b]);
        zero  = (mdl[b] == '0);
        ctl_a = a; ctl_b = b; ctl_d = 2'b11; ctl_e = 1'b1; ctl_f = 1'b1;
        push(tag, a, exp_v);
        tick();
        lat = 1;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_dz"}, div_zero, zero);
        if (clobber) begin
            ld_we = 1'b1; ld_addr = b; ld_data = 16'h0001; mdl[b] = 16'h0001;
        end
        while (continue_o !== 1'b1 && lat < 40) begin
            tick();
            ld_we = 1'b0;
            lat++;
        end
        ld_we = 1'b0;
        check({tag, "_lat"}, lat, QW + 1);
        rd_addr = a;
        #1;
        check({tag, "_nowr"}, rd_data, old_v);
        tick();
        ctl_e = 1'b0; ctl_f = 1'b0;
        check({tag, "_cont_off"}, continue_o, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0;
        ctl_a = '0; ctl_b = '0; ctl_d = '0; ctl_e = 1'b0; ctl_f = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cont", continue_o, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        rd_addr = 5'd5;
        #1;
        check("rst_bank", rd_data, 16'h0000);
        rst_n = 1'b1;
        tick();

        load(5'd1, 16'h0300); load(5'd2, 16'h0180);
        op_single(5'd1, 5'd2, 2'b00, "add");
        load(5'd1, 16'h0300);
        op_single(5'd1, 5'd2, 2'b10, "mul");
        load(5'd1, 16'h0300);
        op_single(5'd1, 5'd2, 2'b01, "sub");

        // Write enable alone still commits an ADD result.
        load(5'd3, 16'h0100); load(5'd4, 16'h0010);
        ctl_a = 5'd3; ctl_b = 5'd4; ctl_d = 2'b00; ctl_e = 1'b0; ctl_f = 1'b1;
        push("add_no_e", 5'd3, m_alu(2'b00, mdl[3], mdl[4]));
        tick();
        ctl_f = 1'b0;
        pop_check();

        load(5'd1, 16'h0300); load(5'd2, 16'h0180);
        run_div(5'd1, 5'd2, 1'b0, "div");
        load(5'd5, 16'hFD00); load(5'd6, 16'h0180);
        run_div(5'd5, 5'd6, 1'b1, "div_neg");
        load(5'd1, 16'h0300); load(5'd2, 16'h0000);
        run_div(5'd1, 5'd2, 1'b0, "div_zero");
        check("div_zero_sticky", div_zero, 1'b1);
        load(5'd14, 16'hFE00); load(5'd15, 16'h0003);
        run_div(5'd14, 5'd15, 1'b0, "div_negsat");

        // Reset in the middle of a DIV.
        load(5'd7, 16'h0300); load(5'd8, 16'h0180);
        ctl_a = 5'd7; ctl_b = 5'd8; ctl_d = 2'b11; ctl_e = 1'b1; ctl_f = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cont", continue_o, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        ctl_e = 1'b0; ctl_f = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        tick();
        rst_n = 1'b1;
        rd_addr = 5'd7;
        #1;
        check("mid_rst_bank", rd_data, 16'h0000);
        tick();
        load(5'd7, 16'h0300); load(5'd8, 16'h0180);
        run_div(5'd7, 5'd8, 1'b0, "div_after_rst");

        load(5'd9, 16'hFE00); load(5'd10, 16'h0180);
        op_single(5'd9, 5'd10, 2'b10, "mul_neg");
        load(5'd9, 16'h7000); load(5'd10, 16'h7000);
        op_single(5'd9, 5'd10, 2'b00, "add_ovf");
        load(5'd9, 16'h8000); load(5'd10, 16'h0001);
        op_single(5'd9, 5'd10, 2'b01, "sub_ovf");

        // Same-address collision: bench load wins.
        load(5'd11, 16'h0100); load(5'd12, 16'h0100);
        ctl_a = 5'd11; ctl_b = 5'd12; ctl_d = 2'b00; ctl_e = 1'b1; ctl_f = 1'b1;
        ld_we = 1'b1; ld_addr = 5'd11; ld_data = 16'h1234;
        push("coll_same", 5'd11, 16'h1234);
        tick();
        ld_we = 1'b0; ctl_e = 1'b0; ctl_f = 1'b0;
        pop_check();

        // Different addresses: both writes land.
        push("coll_diff_int", 5'd11, m_alu(2'b00, mdl[11], mdl[12]));
        ctl_a = 5'd11; ctl_b = 5'd12; ctl_d = 2'b00; ctl_e = 1'b1; ctl_f = 1'b1;
        ld_we = 1'b1; ld_addr = 5'd13; ld_data = 16'h5555;
        push("coll_diff_ld", 5'd13, 16'h5555);
        tick();
        ld_we = 1'b0; ctl_e = 1'b0; ctl_f = 1'b0;
        pop_check();
        pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
